// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the clock, issues a start bit,
// shifts out 8 data bits LSB first plus odd parity and stop, then samples
// the device ACK on the 11th falling edge.
// Optional watchdog: define PS2_TX_TIMEOUT_EN to abort stalled transfers.
`timescale 1ns/1ps
module ps2_host_tx #(
  parameter int CLK_FREQ_HZ = 50000000,
  parameter int INHIBIT_US  = 100,
  parameter int TIMEOUT_US  = 15000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] send_data,
  input  logic       send_req,
  output logic       busy,
  output logic       done,
  output logic       error,
  input  logic       PS2_C_in,
  input  logic       PS2_D_in,
  output logic       PS2_C_oe,
  output logic       PS2_D_oe
);

  localparam longint unsigned INH_RAW = (64'(CLK_FREQ_HZ) * 64'(INHIBIT_US)) / 64'd1000000;
  localparam longint unsigned INH_CYC = (INH_RAW == 0) ? 1 : INH_RAW;
  localparam int              IW      = (INH_CYC <= 2) ? 1 : $clog2(INH_CYC);
  localparam logic [IW-1:0]   INH_LOAD = IW'(INH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, INHIBIT, START, SHIFT, ACK, WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    c_sync_q, d_sync_q;
  logic          c_prev_q;
  logic [7:0]    data_q, data_d;
  logic          par_q, par_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d, bit_nxt;
  logic [IW-1:0] inh_q, inh_d;
  logic          d_oe_q, d_oe_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic          c_s, d_s, c_fall;
  logic          wd_expired;

  assign c_s    = c_sync_q[1];
  assign d_s    = d_sync_q[1];
  assign c_fall = c_prev_q & ~c_s;

  // Pad synchronizers and clock edge history; idle lines read as 1.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      c_sync_q <= 2'b11;
      d_sync_q <= 2'b11;
      c_prev_q <= 1'b1;
    end else begin
      c_sync_q <= {c_sync_q[0], PS2_C_in};
      d_sync_q <= {d_sync_q[0], PS2_D_in};
      c_prev_q <= c_s;
    end
  end

`ifdef PS2_TX_TIMEOUT_EN
  localparam longint unsigned TO_RAW  = (64'(CLK_FREQ_HZ) * 64'(TIMEOUT_US)) / 64'd1000000;
  localparam longint unsigned TO_CYC  = (TO_RAW < 2) ? 2 : TO_RAW;
  localparam int              TW      = (TO_CYC <= 2) ? 1 : $clog2(TO_CYC);
  // START already accounts for one cycle, the expiry transition for another.
  localparam logic [TW-1:0]   TO_LOAD = TW'(TO_CYC - 2);

  logic [TW-1:0] wd_q, wd_d;
  logic          wd_active;

  assign wd_active  = (state_q == SHIFT) || (state_q == ACK);
  assign wd_expired = wd_active && (wd_q == '0);

  // Watchdog down-counter armed in START, running until the ACK is sampled.
  always_comb begin
    wd_d = wd_q;
    if (state_q == START) wd_d = TO_LOAD;
    else if (wd_active && (wd_q != '0)) wd_d = wd_q - TW'(1);
  end

  // Watchdog register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_US != 0);
  assign wd_expired     = 1'b0;
`endif

  // Next-state and datapath decisions for the transfer sequence.
  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    par_d     = par_q;
    bit_cnt_d = bit_cnt_q;
    inh_d     = inh_q;
    d_oe_d    = d_oe_q;
    err_d     = err_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    bit_nxt   = bit_cnt_q + 4'd1;
    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        d_oe_d = 1'b0;
        if (send_req) begin
          data_d    = send_data;
          par_d     = ~^send_data;
          bit_cnt_d = 4'd0;
          inh_d     = INH_LOAD;
          err_d     = 1'b0;
          busy_d    = 1'b1;
          state_d   = INHIBIT;
        end
      end
      INHIBIT: begin
        if (inh_q == '0) state_d = START;
        else             inh_d   = inh_q - IW'(1);
      end
      START: begin
        d_oe_d  = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        if (c_fall) begin
          bit_cnt_d = bit_nxt;
          if (bit_nxt <= 4'd8) begin
            d_oe_d = ~data_q[bit_cnt_q[2:0]];
          end else if (bit_nxt == 4'd9) begin
            d_oe_d = ~par_q;
          end else begin
            d_oe_d  = 1'b0;
            state_d = ACK;
          end
        end
      end
      ACK: begin
        if (c_fall) begin
          err_d   = d_s;
          state_d = WAIT_IDLE;
        end
      end
      WAIT_IDLE: begin
        d_oe_d = 1'b0;
        if (c_s && d_s) begin
          done_d  = 1'b1;
          error_d = err_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (wd_expired) begin
      d_oe_d  = 1'b0;
      err_d   = 1'b1;
      state_d = WAIT_IDLE;
    end
  end

  // State and datapath registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      data_q    <= 8'h00;
      par_q     <= 1'b0;
      bit_cnt_q <= 4'd0;
      inh_q     <= '0;
      d_oe_q    <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      data_q    <= data_d;
      par_q     <= par_d;
      bit_cnt_q <= bit_cnt_d;
      inh_q     <= inh_d;
      d_oe_q    <= d_oe_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Line drivers decode straight from state so reset frees both lines at once.
  assign PS2_C_oe = (state_q == INHIBIT);
  assign PS2_D_oe = (state_q == START) || ((state_q == SHIFT) && d_oe_q);
  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  localparam int CLK_HZ  = 1000000;
  localparam int INH_US  = 100;
  localparam int TO_US   = 200;
  localparam int INH_CYC = 100;   // 1 MHz * 100 us
  localparam int HALF    = 10;

  logic       CLK = 1'b0;
  logic       RESET;
  logic [7:0] send_data;
  logic       send_req;
  logic       busy, done, error;
  logic       PS2_C_oe, PS2_D_oe;
  logic       dev_c_low, dev_d_low;
  logic       c_line, d_line;

  assign c_line = ~(PS2_C_oe | dev_c_low);
  assign d_line = ~(PS2_D_oe | dev_d_low);

  ps2_host_tx #(.CLK_FREQ_HZ(CLK_HZ), .INHIBIT_US(INH_US), .TIMEOUT_US(TO_US)) dut (
    .CLK(CLK), .RESET(RESET), .send_data(send_data), .send_req(send_req),
    .busy(busy), .done(done), .error(error),
    .PS2_C_in(c_line), .PS2_D_in(d_line),
    .PS2_C_oe(PS2_C_oe), .PS2_D_oe(PS2_D_oe)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        err;
    logic        chk;
    logic [10:0] fr;
  } exp_t;

  exp_t        exp_q[$];
  logic [10:0] rx_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Scoreboard monitor: every done pulse is matched to the oldest expectation.
  always @(negedge CLK) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("done_error", error, e.err);
        check("done_busy_low", busy, 0);
        if (e.chk) begin
          if (rx_q.size() == 0) check("rx_frame_present", 0, 1);
          else check("rx_frame", rx_q.pop_front(), e.fr);
        end
      end
    end
  end

  task automatic push_exp(input logic err, input logic chk, input logic [10:0] fr);
    exp_t e;
    e.err = err; e.chk = chk; e.fr = fr;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d);
    @(negedge CLK);
    send_data = d;
    send_req  = 1'b1;
    @(negedge CLK);
    send_req  = 1'b0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < limit) begin @(negedge CLK); n++; end
    if (busy !== 1'b0) check("wait_idle_timeout", busy, 0);
    repeat (2) @(negedge CLK);
  endtask

  // Device model: measures the inhibit, clocks the frame, samples on rising
  // edges, and answers with ACK (data low) or NACK on the 11th clock.
  task automatic dev_xfer(input bit nack, input int abort_edge);
    int n;
    logic [10:0] fr;
    fr = '0;
    n = 0;
    while (PS2_C_oe !== 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    if (PS2_C_oe !== 1'b1) begin check("inhibit_seen", 0, 1); return; end
    n = 0;
    while (PS2_C_oe === 1'b1 && n < 20000) begin @(negedge CLK); n++; end
    check("inhibit_len", n, INH_CYC);
    repeat (HALF) @(negedge CLK);
    fr[0] = d_line;
    for (int e = 1; e <= 11; e++) begin
      dev_c_low = 1'b1;
      if (e == abort_edge) return;
      repeat (HALF) @(negedge CLK);
      dev_c_low = 1'b0;
      if (e <= 10) fr[e] = d_line;
      if (e == 10) begin
        rx_q.push_back(fr);
        dev_d_low = !nack;
      end
      repeat (HALF) @(negedge CLK);
    end
    dev_d_low = 1'b0;
  endtask

  initial begin
    int n;
    RESET = 1'b1; send_req = 1'b0; send_data = 8'h00;
    dev_c_low = 1'b0; dev_d_low = 1'b0;
    repeat (5) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_c_oe", PS2_C_oe, 0);
    check("rst_d_oe", PS2_D_oe, 0);

    // Request on the very first edge after reset release, with a
    // second request during the transfer that must be ignored.
    @(negedge CLK);
    RESET = 1'b0; send_data = 8'hED; send_req = 1'b1;
    push_exp(1'b0, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    @(negedge CLK);
    send_req = 1'b0;
    check("busy_after_first_req", busy, 1);
    fork
      dev_xfer(1'b0, 0);
      begin
        repeat (300) @(negedge CLK);
        check("busy_mid_xfer", busy, 1);
        send_data = 8'h00; send_req = 1'b1;
        @(negedge CLK);
        send_req = 1'b0;
      end
    join
    wait_idle(3000);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (PS2_C_oe === 1'b1 || busy === 1'b1) n++;
    end
    check("no_queued_xfer", n, 0);

    send(8'hF4);
    push_exp(1'b0, 1'b1, {1'b1, 1'b0, 8'hF4, 1'b0});
    dev_xfer(1'b0, 0);
    wait_idle(3000);

    send(8'hFF);
    push_exp(1'b1, 1'b1, {1'b1, 1'b1, 8'hFF, 1'b0});
    dev_xfer(1'b1, 0);
    wait_idle(3000);

    // Reset in the middle of the frame (bit 4 of 0xED is 0, so data is driven).
    send(8'hED);
    dev_xfer(1'b0, 5);
    repeat (4) @(negedge CLK);
    check("pre_rst_d_oe", PS2_D_oe, 1);
    check("pre_rst_busy", busy, 1);
    #3 RESET = 1'b1;
    #1;
    check("midrst_c_oe", PS2_C_oe, 0);
    check("midrst_d_oe", PS2_D_oe, 0);
    check("midrst_busy", busy, 0);
    @(negedge CLK);
    dev_c_low = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    send(8'hED);
    push_exp(1'b0, 1'b1, {1'b1, 1'b1, 8'hED, 1'b0});
    dev_xfer(1'b0, 0);
    wait_idle(3000);

    // Device never clocks.
    send(8'h55);
`ifdef PS2_TX_TIMEOUT_EN
    push_exp(1'b1, 1'b0, 11'h000);
    wait_idle(2000);
    check("to_c_oe", PS2_C_oe, 0);
    check("to_d_oe", PS2_D_oe, 0);
`else
    n = 0;
    while (PS2_C_oe !== 1'b1 && n < 100) begin @(negedge CLK); n++; end
    n = 0;
    while (PS2_C_oe === 1'b1 && n < 2000) begin @(negedge CLK); n++; end
    repeat (1000) @(negedge CLK);
    check("stall_busy", busy, 1);
    check("stall_c_oe", PS2_C_oe, 0);
    check("stall_start_bit", PS2_D_oe, 1);
    @(negedge CLK);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    check("stall_cleared", busy, 0);
`endif

    repeat (5) @(negedge CLK);
    check("exp_q_drained", exp_q.size(), 0);
    check("rx_q_drained", rx_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
